vga_line_fetch: RTL and testbench

Fill engine for the VGA ping-pong line buffers. It responds to the display side's per-line fetch requests (read_buffA_req / read_buffB_req, line index read_buff_addr). For each request it issues fixed-length burst reads to the frame-buffer memory port and writes the returned RGB565 words into the write port of line buffer A or B. It runs entirely in the pixel clock domain. Memory-side arbitration is outside this block.

---
 rtl/vga_line_fetch.sv | 177 +++++++++++++++++
 tb/tb_vga_line_fetch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// Line-buffer fill engine: turns per-line fetch requests from the display side
// into fixed-length burst reads and writes the returned pixels into buffer A or B.
module vga_line_fetch #(
  parameter int ADDR_W      = 24,
  parameter int BURST_LEN   = 16,
  parameter int STRIDE_LOG2 = 10
) (
  input  logic              vga_clk,
  input  logic              rst_n_w,
  input  logic              vga_mode,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              read_buffA_req,
  input  logic              read_buffB_req,
  input  logic [9:0]        read_buff_addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_data,
  output logic              buff_writeA_en,
  output logic [9:0]        buff_writeA_addr,
  output logic [15:0]       buff_writeA_data,
  output logic              buff_writeB_en,
  output logic [9:0]        buff_writeB_addr,
  output logic [15:0]       buff_writeB_data,
  output logic              busy,
  output logic              line_done,
  output logic              abort,
  output logic              overrun
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {IDLE, REQ, DATA, DONE, DRAIN} state_t;

  state_t              state;
  logic                prev_a, prev_b;
  logic                tgt_b;
  logic [ADDR_W-1:0]   base;
  logic [10:0]         wcnt, words;
  logic [BEAT_W-1:0]   beat;

  logic                edge_a, edge_b, any_edge, tgt_lvl;
  logic                last_beat, last_word;
  logic [10:0]         wcnt_nxt;
  logic [ADDR_W-1:0]   start_addr;

  always_comb begin
    edge_a     = read_buffA_req & ~prev_a;
    edge_b     = read_buffB_req & ~prev_b;
    any_edge   = edge_a | edge_b;
    tgt_lvl    = tgt_b ? read_buffB_req : read_buffA_req;
    wcnt_nxt   = wcnt + 11'd1;
    last_beat  = (beat == BEAT_W'(BURST_LEN - 1));
    last_word  = (wcnt_nxt == words);
    start_addr = fb_base + (ADDR_W'(read_buff_addr) << STRIDE_LOG2);
  end

  always_ff @(posedge vga_clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      state            <= IDLE;
      prev_a           <= 1'b0;
      prev_b           <= 1'b0;
      tgt_b            <= 1'b0;
      base             <= '0;
      wcnt             <= '0;
      words            <= '0;
      beat             <= '0;
      mem_rd_req       <= 1'b0;
      mem_rd_addr      <= '0;
      buff_writeA_en   <= 1'b0;
      buff_writeA_addr <= '0;
      buff_writeA_data <= '0;
      buff_writeB_en   <= 1'b0;
      buff_writeB_addr <= '0;
      buff_writeB_data <= '0;
      busy             <= 1'b0;
      line_done        <= 1'b0;
      abort            <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      prev_a         <= read_buffA_req;
      prev_b         <= read_buffB_req;
      buff_writeA_en <= 1'b0;
      buff_writeB_en <= 1'b0;
      line_done      <= 1'b0;
      abort          <= 1'b0;
      overrun        <= (state != IDLE) && any_edge;

      case (state)
        IDLE: begin
          // A wins a simultaneous edge; the B request is reported as dropped
          overrun <= edge_a & edge_b;
          if (any_edge) begin
            tgt_b       <= ~edge_a;
            words       <= vga_mode ? 11'd1024 : 11'd640;
            base        <= start_addr;
            mem_rd_addr <= start_addr;
            mem_rd_req  <= 1'b1;
            wcnt        <= '0;
            beat        <= '0;
            busy        <= 1'b1;
            state       <= REQ;
          end
        end

        REQ: begin
          if (mem_rd_req && mem_rd_ack) begin
            // an accepted burst must always be consumed, even if the line was abandoned
            mem_rd_req <= 1'b0;
            beat       <= '0;
            state      <= tgt_lvl ? DATA : DRAIN;
          end else if (!tgt_lvl) begin
            mem_rd_req <= 1'b0;
            abort      <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        DATA: begin
          if (!tgt_lvl) begin
            if (mem_rd_valid && last_beat) begin
              abort <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              if (mem_rd_valid) beat <= beat + 1'b1;
              state <= DRAIN;
            end
          end else if (mem_rd_valid) begin
            if (tgt_b) begin
              buff_writeB_en   <= 1'b1;
              buff_writeB_addr <= wcnt[9:0];
              buff_writeB_data <= mem_rd_data;
            end else begin
              buff_writeA_en   <= 1'b1;
              buff_writeA_addr <= wcnt[9:0];
              buff_writeA_data <= mem_rd_data;
            end
            wcnt <= wcnt_nxt;
            beat <= beat + 1'b1;
            if (last_beat) begin
              if (last_word) begin
                line_done <= 1'b1;
                state     <= DONE;
              end else begin
                mem_rd_req  <= 1'b1;
                mem_rd_addr <= base + ADDR_W'(wcnt_nxt);
                state       <= REQ;
              end
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        DRAIN: begin
          if (mem_rd_valid) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              abort <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: a burst memory model feeds the DUT while a
// monitor checks every buffer write against the expected line base address.
module tb_vga_line_fetch;

  localparam int ADDR_W = 24;
  localparam int BL     = 16;

  logic              vga_clk = 1'b0;
  logic              rst_n_w = 1'b0;
  logic              vga_mode = 1'b0;
  logic [ADDR_W-1:0] fb_base = '0;
  logic              read_buffA_req = 1'b0;
  logic              read_buffB_req = 1'b0;
  logic [9:0]        read_buff_addr = '0;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ack = 1'b0;
  logic              mem_rd_valid = 1'b0;
  logic [15:0]       mem_rd_data = '0;
  logic              buff_writeA_en, buff_writeB_en;
  logic [9:0]        buff_writeA_addr, buff_writeB_addr;
  logic [15:0]       buff_writeA_data, buff_writeB_data;
  logic              busy, line_done, abort, overrun;
  logic              any_out;

  vga_line_fetch #(.ADDR_W(ADDR_W), .BURST_LEN(BL), .STRIDE_LOG2(10)) dut (
    .vga_clk(vga_clk), .rst_n_w(rst_n_w), .vga_mode(vga_mode), .fb_base(fb_base),
    .read_buffA_req(read_buffA_req), .read_buffB_req(read_buffB_req),
    .read_buff_addr(read_buff_addr), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .buff_writeA_en(buff_writeA_en), .buff_writeA_addr(buff_writeA_addr),
    .buff_writeA_data(buff_writeA_data), .buff_writeB_en(buff_writeB_en),
    .buff_writeB_addr(buff_writeB_addr), .buff_writeB_data(buff_writeB_data),
    .busy(busy), .line_done(line_done), .abort(abort), .overrun(overrun)
  );

  always #5 vga_clk = ~vga_clk;

  assign any_out = |{mem_rd_req, mem_rd_addr, buff_writeA_en, buff_writeA_addr, buff_writeA_data,
                     buff_writeB_en, buff_writeB_addr, buff_writeB_data, busy, line_done, abort, overrun};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Environment state: written only by the env process, except the tokens/levels from main
  int clr_tok = 0, clr_seen = 0, stray_tok = 0, stray_seen = 0, stray_left = 0;
  bit mem_kill = 1'b0;
  logic [ADDR_W-1:0] exp_base = '0;
  int a_cnt, b_cnt, last_a, last_b, a_bad, b_bad, bursts, baddr_bad, reqhold_bad;
  int req_rise, done_cnt, abort_cnt, ovr_cnt, req_cyc, beat, mstate;
  bit stalled, req_q;
  logic [ADDR_W-1:0] maddr, wexp;

  initial begin
    a_cnt = 0; b_cnt = 0; last_a = 0; last_b = 0; a_bad = 0; b_bad = 0; bursts = 0;
    baddr_bad = 0; reqhold_bad = 0; req_rise = 0; done_cnt = 0; abort_cnt = 0; ovr_cnt = 0;
    req_cyc = 0; beat = 0; mstate = 0; stalled = 0; req_q = 0; maddr = '0; wexp = '0;
    forever begin
      @(negedge vga_clk);
      if (clr_tok != clr_seen) begin
        clr_seen = clr_tok;
        a_cnt = 0; b_cnt = 0; last_a = 0; last_b = 0; a_bad = 0; b_bad = 0; bursts = 0;
        baddr_bad = 0; reqhold_bad = 0; req_rise = 0; done_cnt = 0; abort_cnt = 0; ovr_cnt = 0;
      end
      if (buff_writeA_en) begin
        wexp = exp_base + ADDR_W'(buff_writeA_addr);
        if (int'(buff_writeA_addr) != a_cnt || buff_writeA_data != wexp[15:0]) a_bad++;
        last_a = int'(buff_writeA_addr);
        a_cnt++;
      end
      if (buff_writeB_en) begin
        wexp = exp_base + ADDR_W'(buff_writeB_addr);
        if (int'(buff_writeB_addr) != b_cnt || buff_writeB_data != wexp[15:0]) b_bad++;
        last_b = int'(buff_writeB_addr);
        b_cnt++;
      end
      if (line_done) done_cnt++;
      if (abort) abort_cnt++;
      if (overrun) ovr_cnt++;
      if (mem_rd_req && !req_q) req_rise++;
      req_q = mem_rd_req;

      // Memory model: ack on the second sampled req cycle, then 16 beats with one stall
      mem_rd_ack = 1'b0;
      mem_rd_valid = 1'b0;
      if (mem_kill) begin
        mstate = 0; req_cyc = 0; stray_left = 0;
      end else begin
        case (mstate)
          0: begin
            if (stray_tok != stray_seen) begin stray_seen = stray_tok; stray_left = 5; end
            if (stray_left > 0) begin
              mem_rd_valid = 1'b1; mem_rd_data = 16'hBEEF; stray_left--;
            end
            if (mem_rd_req) begin
              req_cyc++;
              if (req_cyc == 2) begin
                mem_rd_ack = 1'b1;
                maddr = mem_rd_addr;
                if (maddr != exp_base + ADDR_W'(bursts * BL)) baddr_bad++;
                bursts++;
                req_cyc = 0;
                mstate = 1;
              end
            end else req_cyc = 0;
          end
          1: begin
            if (mem_rd_req) reqhold_bad++;
            mem_rd_valid = 1'b1; mem_rd_data = maddr[15:0];
            beat = 1; stalled = 0; mstate = 2;
          end
          default: begin
            if (beat == 7 && !stalled) stalled = 1;
            else begin
              mem_rd_valid = 1'b1;
              mem_rd_data = maddr[15:0] + 16'(beat);
              beat++;
              if (beat == BL) mstate = 0;
            end
          end
        endcase
      end
    end
  end

  typedef struct {
    logic              mode;
    logic [ADDR_W-1:0] fb;
    logic [9:0]        line;
    logic              tgt_b;
    logic [ADDR_W-1:0] first;
    int                nbursts;
    int                nwrites;
    int                last;
  } vec_t;

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge vga_clk);
  endtask

  task automatic clear_env();
    clr_tok++;
    wait_cycles(2);
  endtask

  task automatic wait_done(input string nm, input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin @(negedge vga_clk); n++; end
    check($sformatf("%s_done_seen", nm), done_cnt != 0, 1);
  endtask

  task automatic run_fetch(input vec_t v, input string nm);
    vga_mode = v.mode; fb_base = v.fb; read_buff_addr = v.line; exp_base = v.first;
    clear_env();
    if (v.tgt_b) read_buffB_req = 1'b1; else read_buffA_req = 1'b1;
    wait_done(nm, 6000);
    read_buffA_req = 1'b0; read_buffB_req = 1'b0;
    wait_cycles(6);
    check($sformatf("%s_done_pulses", nm), done_cnt, 1);
    check($sformatf("%s_bursts", nm), bursts, v.nbursts);
    check($sformatf("%s_req_rises", nm), req_rise, v.nbursts);
    check($sformatf("%s_burst_addr_bad", nm), baddr_bad, 0);
    check($sformatf("%s_req_after_ack", nm), reqhold_bad, 0);
    check($sformatf("%s_tgt_writes", nm), v.tgt_b ? b_cnt : a_cnt, v.nwrites);
    check($sformatf("%s_tgt_last_addr", nm), v.tgt_b ? last_b : last_a, v.last);
    check($sformatf("%s_tgt_bad_writes", nm), v.tgt_b ? b_bad : a_bad, 0);
    check($sformatf("%s_other_writes", nm), v.tgt_b ? a_cnt : b_cnt, 0);
    check($sformatf("%s_abort", nm), abort_cnt, 0);
    check($sformatf("%s_overrun", nm), ovr_cnt, 0);
    check($sformatf("%s_busy_end", nm), busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vec_t vb;
    int n;

    // mode, fb_base, line, tgt_b, first burst addr, bursts, writes, last addr
    vecs[0] = '{1'b0, 24'h000000, 10'd5,    1'b0, 24'h001400, 40, 640,  639};
    vecs[1] = '{1'b1, 24'h100000, 10'd767,  1'b1, 24'h1BFC00, 64, 1024, 1023};
    vecs[2] = '{1'b0, 24'hFFFF00, 10'd1023, 1'b0, 24'h0FFB00, 40, 640,  639};
    vecs[3] = '{1'b1, 24'h000123, 10'd0,    1'b0, 24'h000123, 64, 1024, 1023};
    vb      = '{1'b0, 24'h000100, 10'd2,    1'b1, 24'h000900, 40, 640,  639};

    // Reset held: inputs toggle, outputs must stay quiet
    stray_tok++;
    for (int i = 0; i < 8; i++) begin
      @(negedge vga_clk);
      read_buffA_req = i[0];
      read_buffB_req = i[1];
      vga_mode       = i[2];
      fb_base        = 24'h5A5A5A ^ ADDR_W'(i * 977);
      read_buff_addr = 10'(i * 131);
      #1 check("rst_outputs_zero", any_out, 0);
    end
    read_buffA_req = 1'b0; read_buffB_req = 1'b0;
    @(negedge vga_clk) rst_n_w = 1'b1;
    clear_env();
    wait_cycles(5);
    check("post_rst_busy", busy, 0);
    check("post_rst_req", mem_rd_req, 0);
    check("post_rst_req_rises", req_rise, 0);

    for (int i = 0; i < 4; i++) run_fetch(vecs[i], $sformatf("vec%0d", i));

    // Abort mid-DATA of burst 3 after its beat 5 is written
    vga_mode = 1'b0; fb_base = '0; read_buff_addr = 10'd5; exp_base = 24'h001400;
    clear_env();
    read_buffA_req = 1'b1;
    n = 0;
    while (!(bursts == 3 && beat == 6 && mstate == 2) && n < 2000) begin @(posedge vga_clk); n++; end
    check("abort_sync_reached", bursts == 3 && beat == 6, 1);
    #1 read_buffA_req = 1'b0;
    wait_cycles(40);
    check("abort_a_writes", a_cnt, 38);
    check("abort_last_addr", last_a, 37);
    check("abort_bad_writes", a_bad, 0);
    check("abort_bursts", bursts, 3);
    check("abort_req_rises", req_rise, 3);
    check("abort_pulses", abort_cnt, 1);
    check("abort_done_pulses", done_cnt, 0);
    check("abort_b_writes", b_cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_req", mem_rd_req, 0);
    run_fetch(vb, "after_abort_b");

    // B edge during an active A fetch
    vga_mode = 1'b0; fb_base = '0; read_buff_addr = 10'd5; exp_base = 24'h001400;
    clear_env();
    read_buffA_req = 1'b1;
    n = 0;
    while (bursts < 2 && n < 2000) begin @(posedge vga_clk); n++; end
    #1 read_buffB_req = 1'b1;
    wait_done("busy_ovr", 6000);
    read_buffA_req = 1'b0; read_buffB_req = 1'b0;
    wait_cycles(6);
    check("busy_ovr_pulses", ovr_cnt, 1);
    check("busy_ovr_a_writes", a_cnt, 640);
    check("busy_ovr_a_bad", a_bad, 0);
    check("busy_ovr_b_writes", b_cnt, 0);
    check("busy_ovr_done", done_cnt, 1);

    // Simultaneous A and B edges in IDLE
    clear_env();
    read_buffA_req = 1'b1; read_buffB_req = 1'b1;
    wait_done("simul", 6000);
    read_buffA_req = 1'b0; read_buffB_req = 1'b0;
    wait_cycles(6);
    check("simul_ovr_pulses", ovr_cnt, 1);
    check("simul_a_writes", a_cnt, 640);
    check("simul_a_bad", a_bad, 0);
    check("simul_b_writes", b_cnt, 0);
    check("simul_last_addr", last_a, 639);

    // Reset during DATA, then stray beats after release
    clear_env();
    read_buffA_req = 1'b1;
    n = 0;
    while (!(bursts == 1 && beat == 4) && n < 2000) begin @(posedge vga_clk); n++; end
    check("rst_mid_sync_reached", bursts == 1 && beat == 4, 1);
    #1 begin mem_kill = 1'b1; rst_n_w = 1'b0; end
    #1 check("rst_mid_outputs_zero", any_out, 0);
    read_buffA_req = 1'b0;
    wait_cycles(3);
    rst_n_w = 1'b1;
    mem_kill = 1'b0;
    clear_env();
    stray_tok++;
    wait_cycles(10);
    check("stray_a_writes", a_cnt, 0);
    check("stray_b_writes", b_cnt, 0);
    check("stray_req", mem_rd_req, 0);
    check("stray_req_rises", req_rise, 0);
    check("stray_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
